// File: rtl/ili934x_win_if.sv
// ili934x_win_if: request, pixel-stream and item-output bundle of the window writer.
// Solid-fill ports exist only with ILI934X_WIN_FILL_EN.
package ili934x_win_pkg;
  typedef struct packed {
    logic       is_cmd;
    logic [7:0] data;
  } wr_item_t;
endpackage

interface ili934x_win_if;
  import ili934x_win_pkg::*;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_x0;
  logic [8:0]  req_x1;
  logic [8:0]  req_y0;
  logic [8:0]  req_y1;
`ifdef ILI934X_WIN_FILL_EN
  logic        req_fill;
  logic [15:0] fill_color;
`endif
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        o_valid;
  logic        o_ready;
  wr_item_t    o_item;
`ifdef ILI934X_WIN_FILL_EN
  modport master (output req_valid, req_x0, req_x1, req_y0, req_y1, req_fill, fill_color, pix_valid, pix_data, o_ready,
                  input req_ready, pix_ready, o_valid, o_item);
  modport slave (input req_valid, req_x0, req_x1, req_y0, req_y1, req_fill, fill_color, pix_valid, pix_data, o_ready,
                 output req_ready, pix_ready, o_valid, o_item);
`else
  modport master (output req_valid, req_x0, req_x1, req_y0, req_y1, pix_valid, pix_data, o_ready,
                  input req_ready, pix_ready, o_valid, o_item);
  modport slave (input req_valid, req_x0, req_x1, req_y0, req_y1, pix_valid, pix_data, o_ready,
                 output req_ready, pix_ready, o_valid, o_item);
`endif
endinterface

// File: rtl/ili934x_win_writer.sv
// ili934x_win_writer: emits CASET/RASET/RAMWR header then RGB565 pixel bytes for one window write.
// Optional solid-fill mode is enabled by defining ILI934X_WIN_FILL_EN.
module ili934x_win_writer
  import ili934x_win_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic         clk,
  input  logic         rst_n,
  ili934x_win_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam logic [8:0] W_LIM = 9'(WIDTH);
  localparam logic [8:0] H_LIM = 9'(HEIGHT);
  typedef enum logic [1:0] {IDLE, HDR, PIX_HI, PIX_LO} state_t;
  state_t      state, state_n;
  logic [8:0]  x0, x1, y0, y1, w, h;
  logic [16:0] cnt, cnt_n;
  logic [3:0]  idx, idx_n;
  logic [7:0]  lo, lo_n;
  logic        ov_n, done_n, err_n, slot, accept, bad, pix_go, fill_q;
  logic [15:0] pix, color_q;
  wr_item_t    item_n;
  wr_item_t    hdr [11];
  assign slot = !bus.o_valid || bus.o_ready;
  assign accept = bus.req_valid && bus.req_ready;
  assign bad = bus.req_x1 < bus.req_x0 || bus.req_y1 < bus.req_y0 || bus.req_x1 >= W_LIM || bus.req_y1 >= H_LIM;
  assign w = bus.req_x1 - bus.req_x0 + 9'd1;
  assign h = bus.req_y1 - bus.req_y0 + 9'd1;
  assign bus.req_ready = rst_n && state == IDLE;
  assign bus.pix_ready = state == PIX_HI && slot && !fill_q;
  assign pix_go = state == PIX_HI && slot && (fill_q || bus.pix_valid);
  assign pix = fill_q ? color_q : bus.pix_data;
  assign busy = state != IDLE;
  // Entry 0 is loaded straight from IDLE so the first command appears one cycle after accept.
  assign hdr = '{9'h12A, {8'd0, x0[8]}, {1'b0, x0[7:0]}, {8'd0, x1[8]}, {1'b0, x1[7:0]},
                 9'h12B, {8'd0, y0[8]}, {1'b0, y0[7:0]}, {8'd0, y1[8]}, {1'b0, y1[7:0]}, 9'h12C};
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    lo_n = lo;
    ov_n = bus.o_valid && !bus.o_ready;
    item_n = bus.o_item;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (accept) begin
        err_n = bad;
        if (!bad) begin
          state_n = HDR;
          idx_n = 4'd1;
          cnt_n = {8'd0, w} * {8'd0, h};
          ov_n = 1'b1;
          item_n = 9'h12A;
        end
      end
      HDR: if (slot) begin
        ov_n = 1'b1;
        item_n = hdr[idx];
        idx_n = idx + 4'd1;
        state_n = idx == 4'd10 ? PIX_HI : HDR;
      end
      PIX_HI: if (pix_go) begin
        ov_n = 1'b1;
        item_n = {1'b0, pix[15:8]};
        lo_n = pix[7:0];
        state_n = PIX_LO;
      end
      PIX_LO:
        // A zero count means the final low byte is in the slot; finish once it is taken.
        if (cnt == 17'd0) begin
          state_n = bus.o_ready ? IDLE : PIX_LO;
          done_n = bus.o_ready;
        end else if (slot) begin
          ov_n = 1'b1;
          item_n = {1'b0, lo};
          cnt_n = cnt - 17'd1;
          state_n = cnt == 17'd1 ? PIX_LO : PIX_HI;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      lo <= '0;
      {x0, x1, y0, y1} <= '0;
      bus.o_valid <= 1'b0;
      bus.o_item <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      lo <= lo_n;
      bus.o_valid <= ov_n;
      bus.o_item <= item_n;
      done <= done_n;
      err <= err_n;
      if (accept) {x0, x1, y0, y1} <= {bus.req_x0, bus.req_x1, bus.req_y0, bus.req_y1};
    end
`ifdef ILI934X_WIN_FILL_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {fill_q, color_q} <= '0;
    else if (accept) {fill_q, color_q} <= {bus.req_fill, bus.fill_color};
`else
  assign fill_q = 1'b0;
  assign color_q = 16'h0000;
`endif
endmodule

// File: tb/tb_ili934x_win_writer.sv
// tb_ili934x_win_writer: scoreboard bench for the window writer; stimulus pushes expected items, a monitor pops them.
module tb_ili934x_win_writer;
  import ili934x_win_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy, done, err;
  logic [8:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  bit bp = 0;
  bit fill_chk = 0;
  bit prev_stall = 0;
  logic [8:0] prev_item;
  logic [8:0] basic_hdr [11] = '{9'h12A, 9'h000, 9'h000, 9'h000, 9'h001, 9'h12B, 9'h000, 9'h000, 9'h000, 9'h000, 9'h12C};
  logic [8:0] tall_hdr [11] = '{9'h12A, 9'h000, 9'h000, 9'h000, 9'h000, 9'h12B, 9'h001, 9'h02C, 9'h001, 9'h03F, 9'h12C};

  ili934x_win_if bus();
  ili934x_win_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_o_valid"}, bus.o_valid, 0);
    check({tag, "_o_item"}, bus.o_item, 0);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_pix_ready"}, bus.pix_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic push_hdr(input logic [8:0] a0, a1, b0, b1);
    exp_q.push_back(9'h12A);
    exp_q.push_back({8'd0, a0[8]}); exp_q.push_back({1'b0, a0[7:0]});
    exp_q.push_back({8'd0, a1[8]}); exp_q.push_back({1'b0, a1[7:0]});
    exp_q.push_back(9'h12B);
    exp_q.push_back({8'd0, b0[8]}); exp_q.push_back({1'b0, b0[7:0]});
    exp_q.push_back({8'd0, b1[8]}); exp_q.push_back({1'b0, b1[7:0]});
    exp_q.push_back(9'h12C);
  endtask

  task automatic request(input logic [8:0] a0, a1, b0, b1, input bit f, input logic [15:0] c);
    @(posedge clk); #1;
    bus.req_x0 = a0; bus.req_x1 = a1; bus.req_y0 = b0; bus.req_y1 = b1;
`ifdef ILI934X_WIN_FILL_EN
    bus.req_fill = f; bus.fill_color = c;
`endif
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [15:0] p);
    int n = 0;
    exp_q.push_back({1'b0, p[15:8]});
    exp_q.push_back({1'b0, p[7:0]});
    bus.pix_data = p;
    bus.pix_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.pix_ready && n < 500);
    if (!bus.pix_ready) begin
      tests++; fails++;
      $display("FAIL pix_timeout: pix_ready still 0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_pulses", done_cnt, target);
    check("busy_idle", busy, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    bus.o_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.o_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_item", bus.o_item, prev_item);
        check("hold_valid", bus.o_valid, 1);
      end
      if (bus.o_valid && bus.o_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_item: got %0h with nothing required", bus.o_item);
        end else check("item", bus.o_item, exp_q.pop_front());
      end
      if (bus.o_valid) valid_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (fill_chk) check("fill_pix_ready", bus.pix_ready, 0);
      prev_stall = bus.o_valid && !bus.o_ready;
      prev_item = bus.o_item;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    bus.req_valid = 0; bus.req_x0 = 0; bus.req_x1 = 0; bus.req_y0 = 0; bus.req_y1 = 0;
    bus.pix_valid = 0; bus.pix_data = 0;
`ifdef ILI934X_WIN_FILL_EN
    bus.req_fill = 0; bus.fill_color = 0;
`endif
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", bus.req_ready, 1);
    // basic 2x1 window
    foreach (basic_hdr[i]) exp_q.push_back(basic_hdr[i]);
    request(0, 1, 0, 0, 0, 16'h0);
    @(negedge clk);
    check("first_latency_valid", bus.o_valid, 1);
    check("first_latency_item", bus.o_item, 9'h12A);
    send_pixel(16'hF800);
    send_pixel(16'h07E0);
    wait_done(1);
    // row coordinates above 255
    foreach (tall_hdr[i]) exp_q.push_back(tall_hdr[i]);
    request(0, 0, 300, 319, 0, 16'h0);
    for (int i = 0; i < 20; i++) send_pixel(16'(i * 16'h1357 + 16'h0A0B));
    wait_done(2);
    // backpressure on a 4x4 window
    bp = 1;
    push_hdr(2, 5, 7, 10);
    request(2, 5, 7, 10, 0, 16'h0);
    for (int i = 0; i < 16; i++) send_pixel(16'($urandom));
    wait_done(3);
    bp = 0;
    // largest legal corner, single pixel
    push_hdr(239, 239, 319, 319);
    request(239, 239, 319, 319, 0, 16'h0);
    send_pixel(16'hBEEF);
    wait_done(4);
    // rejected requests
    vc = valid_cnt;
    request(6, 5, 0, 0, 0, 16'h0);
    repeat (4) @(posedge clk);
    check("err_x_order", err_cnt, 1);
    check("err_x_no_valid", valid_cnt, vc);
    request(0, 0, 0, 320, 0, 16'h0);
    repeat (4) @(posedge clk);
    check("err_y_range", err_cnt, 2);
    check("err_y_no_valid", valid_cnt, vc);
    request(240, 240, 0, 0, 0, 16'h0);
    repeat (4) @(posedge clk);
    check("err_x_range", err_cnt, 3);
    check("err_x_range_no_valid", valid_cnt, vc);
    // reset in the middle of a 10x10 frame
    push_hdr(0, 9, 0, 9);
    request(0, 9, 0, 9, 0, 16'h0);
    for (int i = 0; i < 3; i++) send_pixel(16'h1111 * 16'(i + 1));
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    check("pre_reset_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_reset_busy", busy, 0);
    push_hdr(0, 1, 0, 0);
    request(0, 1, 0, 0, 0, 16'h0);
    send_pixel(16'h1234);
    send_pixel(16'h5678);
    wait_done(5);
`ifdef ILI934X_WIN_FILL_EN
    // solid fill with a pixel offered throughout that must be ignored
    fill_chk = 1;
    bus.pix_valid = 1'b1;
    bus.pix_data = 16'hABCD;
    push_hdr(4, 6, 2, 2);
    for (int i = 0; i < 3; i++) begin exp_q.push_back(9'h000); exp_q.push_back(9'h01F); end
    request(4, 6, 2, 2, 1, 16'h001F);
    wait_done(6);
    fill_chk = 0;
    bus.pix_valid = 1'b0;
`endif
    repeat (5) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ili934x_win_writer.md
# ili934x_win_writer

Window-write sequencer for the ILI934x TFT path. Accepts a rectangle request plus an RGB565 pixel stream and emits the complete byte-level write transaction as `wr_item_t` items: a CASET/RASET/RAMWR header, then every pixel as high byte followed by low byte. It drives the lower-priority (stream) input of the two-source arbiter that feeds the SPI command/data FIFO.

## Interface
- `WIDTH`, 240 — panel columns; a request with `x1 >= WIDTH` is rejected.
- `HEIGHT`, 320 — panel rows; a request with `y1 >= HEIGHT` is rejected.
- `clk`  in  1  — sole clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — rectangle request valid.
- `req_ready`  out  1  — request accepted when `req_valid && req_ready`.
- `req_x0`, `req_x1`, `req_y0`, `req_y1`  in  9 each  — inclusive window corners.
- `req_fill`  in  1  — solid-fill request (present only with `ILI934X_WIN_FILL_EN`).
- `fill_color`  in  16  — fill colour, sampled at request accept (present only with `ILI934X_WIN_FILL_EN`).
- `pix_valid`  in  1, `pix_data`  in  16, `pix_ready`  out  1  — RGB565 pixel stream.
- `o_valid`  out  1, `o_item`  out  `wr_item_t`, `o_ready`  in  1  — item output to the arbiter's B side.
- `busy`  out  1  — high whenever the state is not IDLE.
- `done`  out  1  — one-cycle pulse after the last item is handed off.
- `err`  out  1  — one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, HDR, PIX_HI, PIX_LO.
- **IDLE**
  - `req_ready = 1`.
  - On accept, latch the corners.
  - Invalid rectangle (`x1 < x0`, `y1 < y0`, `x1 >= WIDTH`, or `y1 >= HEIGHT`): pulse `err` on the next cycle, stay in IDLE, emit nothing.
  - Valid rectangle: load a 17-bit pixel counter with `(x1-x0+1)*(y1-y0+1)` and go to HDR with header index 0.
- **HDR** emits 11 items in this order:
  - cmd `0x2A`
  - data `{7'b0,x0[8]}`, `x0[7:0]`, `{7'b0,x1[8]}`, `x1[7:0]`
  - cmd `0x2B`
  - data for y0 and y1, same byte format as x
  - cmd `0x2C`
  - After index 10 hands off, go to PIX_HI.
- **PIX_HI**
  - `pix_ready` is high when the output slot is free (`!o_valid || o_ready`).
  - On pixel accept: emit data `pix_data[15:8]`, latch `pix_data[7:0]`, go to PIX_LO.
- **PIX_LO**
  - When the slot is free, emit the latched low byte and decrement the counter.
  - Counter reaches 0 → IDLE and pulse `done`. Otherwise → PIX_HI.
- `is_cmd = 1` only for `0x2A`, `0x2B` and `0x2C`.
- Counter arithmetic is unsigned. The 17-bit width covers 240×320 = 76800.

## Timing
- Reset values: `o_valid = 0`, `o_item = '{0, 8'h00}`, `req_ready = 0` during reset (then 1 in IDLE), `pix_ready = 0`, `busy = 0`, `done = 0`, `err = 0`.
- `o_valid` and `o_item` are registered:
  - An item appears the cycle after its source event (request accept, header step, or pixel accept).
  - While `o_valid && !o_ready`, `o_item` holds stable and no new item is loaded.
- Throughput is one item per cycle while `o_ready` is held high. A single pixel costs 2 cycles; there is no bubble between PIX_LO and the next PIX_HI.
- Request-accept → first `0x2A` on `o_valid`: 1 cycle.
- `done` asserts in the cycle after the final low byte's `o_valid && o_ready` handshake.
- `pix_ready` is never high outside PIX_HI. Pixels offered early are simply held off.
- Reset asserted mid-transaction:
  - Returns to IDLE immediately with all outputs at their reset values.
  - The partial frame is abandoned; the next request re-sends the full header.
- Arbiter starvation (`o_ready` low for many cycles) stalls all states without losing data.

## Configuration
- **`ILI934X_WIN_FILL_EN` defined:**
  - `req_fill` and `fill_color` ports exist.
  - With `req_fill = 1` at accept, the colour is latched, `pix_ready` stays 0 for the whole transaction, and every pixel's bytes are `fill_color[15:8]` then `fill_color[7:0]`.
  - `req_fill = 0` behaves as stream mode.
- **Not defined:** the ports are absent and the block is stream-only.

## Test plan
- **Basic write.** Request (0,0)-(1,0), `o_ready = 1`, pixels `0xF800`, `0x07E0`. Expect:
  - cmd `2A`, data `00 00 00 01`
  - cmd `2B`, data `00 00 00 00`
  - cmd `2C`, data `F8 00 07 E0`
  - `done` pulses once and `busy` falls.
- **Bit-8 coordinates.** Request (0,300)-(0,319). Expect RASET data `01 2C 01 3F`, then 20 pixels (40 bytes).
- **Backpressure.** Toggle `o_ready` pseudo-randomly (roughly 50% low) across a 4×4 window with a random pixel stream. Expect:
  - the item sequence is identical to the `o_ready = 1` run;
  - `o_item` never changes while `o_valid && !o_ready`.
- **Rejection.**
  - Request with `x1 = 5`, `x0 = 6`: `err` pulses, no `o_valid`.
  - Request with `y1 = 320`: same result.
- **Reset mid-stream.** Assert `rst_n = 0` after 3 pixels of a 10×10 window. Expect all outputs at reset values; the next request starts again with cmd `0x2A`.
- **Fill mode (`ILI934X_WIN_FILL_EN`).** Request with `req_fill = 1`, `fill_color = 0x001F`, window 3×1. Expect data `00 1F` three times and `pix_ready = 0` throughout.
